reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter: DATA_W, 16, register and bus width in bits.
REQ-002 Parameter: PC_IDX, 7, index of the program-counter register.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 regOes  input  8  one-hot output-enable strobes, bit i selects register i.
REQ-006 regLoads  input  8  one-hot load strobes, bit i selects register i.
REQ-007 dataIn  input  DATA_W  write data from shared bus.
REQ-008 pcInc  input  1  increment register PC_IDX this cycle.
REQ-009 errClear  input  1  clear sticky error flag.
REQ-010 dataOut  output  DATA_W  selected register value onto shared bus.
REQ-011 busDriven  output  1  high when exactly one regOes bit is set.
REQ-012 errFlag  output  1  sticky strobe-violation flag.

Function
REQ-013 Block SHALL hold eight DATA_W-bit registers r0..r7.
REQ-014 regLoads exactly one-hot bit i: r[i] SHALL take dataIn at the next rising edge.
REQ-015 regLoads all zero: no register SHALL change, except by pcInc.
REQ-016 regLoads with more than one bit set: no register SHALL be written; errFlag SHALL set at the next edge.
REQ-017 regOes exactly one-hot bit i: dataOut SHALL equal r[i] combinationally, zero-cycle latency; busDriven=1.
REQ-018 regOes zero or multi-hot: dataOut SHALL be 0, busDriven=0; multi-hot SHALL set errFlag at the next edge.
REQ-019 pcInc=1: r[PC_IDX] SHALL become r[PC_IDX]+1 modulo 2^DATA_W (0xFFFF wraps to 0x0000).
REQ-020 pcInc with valid load of r[PC_IDX] in the same cycle: load SHALL win, no increment.
REQ-021 pcInc with a valid load of another register in the same cycle: both SHALL take effect.
REQ-022 Same register selected by regOes and regLoads in one cycle: dataOut SHALL show the pre-edge value (bypass per REQ-027).
REQ-023 errFlag SHALL stay set until errClear=1; a new violation in the same cycle as errClear SHALL leave errFlag set.

Reset
REQ-024 reset=1 at a rising edge SHALL clear r0..r7 and errFlag to 0, overriding loads, pcInc and errClear that cycle.
REQ-025 After reset with regOes=0: dataOut=0, busDriven=0, errFlag=0.
REQ-026 Reset asserted mid-sequence SHALL discard any pending effect; no partial write SHALL survive.

Configuration
REQ-027 REG_BANK_BYPASS_EN defined: when regOes and regLoads select the same single register, dataOut SHALL equal dataIn; undefined: dataOut SHALL equal the stored value. Bypass SHALL never apply to pcInc-only updates.

Structure
REQ-028 Shared package esc_pkg SHALL hold DATA_W, NREGS (8), PC_IDX and the 3-bit register-index type.
REQ-029 Sub-module onehot_chk SHALL take an 8-bit vector and return isOneHot, isZero and the 3-bit encoded index; reg_bank SHALL instantiate it twice (regOes, regLoads).

Verification
REQ-030 reset; regLoads=0x04, dataIn=0x1234; next cycle regOes=0x04 -> dataOut=0x1234, busDriven=1, errFlag=0.
REQ-031 r7=0xFFFF, pcInc=1 -> r7=0x0000; then pcInc=1 with regLoads=0x80, dataIn=0x0100 -> r7=0x0100.
REQ-032 regLoads=0x03, dataIn=0xBEEF -> r0, r1 unchanged, errFlag=1; errClear=1 with regOes=0x06 same cycle -> errFlag stays 1; errClear=1 alone -> errFlag=0.
REQ-033 r2=0x0011; regOes=0x04, regLoads=0x04, dataIn=0x00AA -> dataOut=0x0011 without macro, 0x00AA with REG_BANK_BYPASS_EN; r2=0x00AA after edge in both builds.
REQ-034 All registers loaded with nonzero values, errFlag=1; reset=1 with regLoads=0x01, pcInc=1 -> all registers 0, errFlag=0.
REQ-035 regOes=0x00 -> dataOut=0x0000, busDriven=0, errFlag unchanged.

Source files
------------

// File: rtl/esc_pkg.sv
// Shared constants and types for the register bank: bus width, register count,
// program-counter index and the 3-bit register index type.
package esc_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int PC_IDX = 7;

  typedef logic [2:0] regIdx_t;

  // Strobe vector with more than one bit set is a protocol violation.
  function automatic logic isMultiHot(input logic [NREGS-1:0] vec);
    return (vec & (vec - {{(NREGS-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/reg_bank_onehot_chk.sv
// Classifies an 8-bit strobe vector as zero / exactly one-hot and encodes
// the index of the set bit (index is only meaningful when isOneHot is high).
import esc_pkg::*;

module onehot_chk (
  input  logic [NREGS-1:0] vec,
  output logic             isOneHot,
  output logic             isZero,
  output regIdx_t          idx
);

  always_comb begin
    isZero   = (vec == '0);
    isOneHot = !isZero && !isMultiHot(vec);
    idx      = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (vec[i]) idx = regIdx_t'(i);
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank on a shared bus with one-hot strobes, a PC
// incrementer and a sticky strobe-violation flag. Optional read-during-write
// bypass is enabled with the REG_BANK_BYPASS_EN macro.
import esc_pkg::*;

module reg_bank #(
  parameter int DATA_W = esc_pkg::DATA_W,
  parameter int PC_IDX = esc_pkg::PC_IDX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREGS-1:0]  regOes,
  input  logic [NREGS-1:0]  regLoads,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              pcInc,
  input  logic              errClear,
  output logic [DATA_W-1:0] dataOut,
  output logic              busDriven,
  output logic              errFlag
);

  localparam regIdx_t PC_SEL = regIdx_t'(PC_IDX);

  logic [DATA_W-1:0] regs [NREGS];

  logic    oeOneHot, oeZero, ldOneHot, ldZero;
  regIdx_t oeIdx, ldIdx;
  logic    violation;
  logic    pcLoaded;

  onehot_chk uOeChk (
    .vec      (regOes),
    .isOneHot (oeOneHot),
    .isZero   (oeZero),
    .idx      (oeIdx)
  );

  onehot_chk uLdChk (
    .vec      (regLoads),
    .isOneHot (ldOneHot),
    .isZero   (ldZero),
    .idx      (ldIdx)
  );

  assign violation = (!oeOneHot && !oeZero) || (!ldOneHot && !ldZero);
  assign pcLoaded  = ldOneHot && (ldIdx == PC_SEL);

  // A load of the PC in the same cycle takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      errFlag <= 1'b0;
    end else begin
      if (pcInc && !pcLoaded) regs[PC_SEL] <= regs[PC_SEL] + DATA_W'(1);
      if (ldOneHot) regs[ldIdx] <= dataIn;
      if (violation) errFlag <= 1'b1;
      else if (errClear) errFlag <= 1'b0;
    end
  end

  always_comb begin
    dataOut   = '0;
    busDriven = oeOneHot;
    if (oeOneHot) begin
`ifdef REG_BANK_BYPASS_EN
      if (ldOneHot && (ldIdx == oeIdx)) dataOut = dataIn;
      else dataOut = regs[oeIdx];
`else
      dataOut = regs[oeIdx];
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_reg_bank;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   regOes = '0;
  logic [7:0]   regLoads = '0;
  logic [W-1:0] dataIn = '0;
  logic         pcInc = 1'b0;
  logic         errClear = 1'b0;
  logic [W-1:0] dataOut;
  logic         busDriven;
  logic         errFlag;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  logic [W-1:0] m [8];
  logic         mErr = 1'b0;

  reg_bank dut (
    .clk       (clk),
    .reset     (reset),
    .regOes    (regOes),
    .regLoads  (regLoads),
    .dataIn    (dataIn),
    .pcInc     (pcInc),
    .errClear  (errClear),
    .dataOut   (dataOut),
    .busDriven (busDriven),
    .errFlag   (errFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int bitIndex(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: state update at every rising edge.
  initial for (int i = 0; i < 8; i++) m[i] = '0;

  always @(posedge clk) begin
    logic [W-1:0] nxt [8];
    logic         nErr;
    for (int i = 0; i < 8; i++) nxt[i] = m[i];
    nErr = mErr;
    if (reset) begin
      for (int i = 0; i < 8; i++) nxt[i] = '0;
      nErr = 1'b0;
    end else begin
      if (pcInc) nxt[7] = m[7] + 16'd1;
      if ($countones(regLoads) == 1) nxt[bitIndex(regLoads)] = dataIn;
      if ($countones(regLoads) > 1 || $countones(regOes) > 1) nErr = 1'b1;
      else if (errClear) nErr = 1'b0;
    end
    for (int i = 0; i < 8; i++) m[i] <= nxt[i];
    mErr <= nErr;
  end

  // Compare process: combinational outputs checked mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      logic [W-1:0] expOut;
      expOut = '0;
      if ($countones(regOes) == 1) begin
        expOut = m[bitIndex(regOes)];
`ifdef REG_BANK_BYPASS_EN
        if (regLoads == regOes) expOut = dataIn;
`endif
      end
      chk("model dataOut", 32'(dataOut), 32'(expOut));
      chk("model busDriven", 32'(busDriven), 32'($countones(regOes) == 1));
      chk("model errFlag", 32'(errFlag), 32'(mErr));
    end
  end

  task automatic drive(input logic [7:0] oe, input logic [7:0] ld, input logic [W-1:0] din,
                       input logic pc, input logic clr, input logic rst);
    regOes = oe; regLoads = ld; dataIn = din; pcInc = pc; errClear = clr; reset = rst;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input string name, input int idx, input logic [W-1:0] exp);
    drive(8'(1 << idx), 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk(name, 32'(dataOut), 32'(exp));
  endtask

  function automatic logic [7:0] randStrobe();
    logic [7:0] v;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) begin
      do v = 8'($urandom); while ($countones(v) < 2);
      return v;
    end
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  initial begin
    @(posedge clk); #1;
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    checkEn = 1;

    // Reset state.
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst dataOut", 32'(dataOut), 32'h0);
    chk("rst busDriven", 32'(busDriven), 32'h0);
    chk("rst errFlag", 32'(errFlag), 32'h0);

    // Load r2 and read it back.
    drive(8'h00, 8'h04, 16'h1234, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h04, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("r2 read", 32'(dataOut), 32'h1234);
    chk("r2 busDriven", 32'(busDriven), 32'h1);
    chk("r2 errFlag", 32'(errFlag), 32'h0);
    tick();

    // PC wrap, then load beats increment.
    drive(8'h00, 8'h80, 16'hFFFF, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 8'h00, 16'h0, 1'b1, 1'b0, 1'b0); tick();
    readReg("pc wrap", 7, 16'h0000); tick();
    drive(8'h00, 8'h80, 16'h0100, 1'b1, 1'b0, 1'b0); tick();
    readReg("pc load wins", 7, 16'h0100); tick();
    // Increment alongside a load of another register.
    drive(8'h00, 8'h08, 16'h0033, 1'b1, 1'b0, 1'b0); tick();
    readReg("pc inc w/ load", 7, 16'h0101); tick();
    readReg("r3 w/ pc inc", 3, 16'h0033); tick();

    // Multi-hot load is rejected and sets the sticky flag.
    drive(8'h00, 8'h01, 16'h000A, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 8'h02, 16'h000B, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 8'h03, 16'hBEEF, 1'b0, 1'b0, 1'b0); tick();
    readReg("r0 kept", 0, 16'h000A);
    chk("err set", 32'(errFlag), 32'h1);
    tick();
    readReg("r1 kept", 1, 16'h000B); tick();
    drive(8'h06, 8'h00, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("multi oe dataOut", 32'(dataOut), 32'h0);
    chk("multi oe busDriven", 32'(busDriven), 32'h0);
    tick();
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("err held vs clear", 32'(errFlag), 32'h1);
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b1, 1'b0); tick();
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("err cleared", 32'(errFlag), 32'h0);

    // Read and write of the same register in one cycle.
    drive(8'h00, 8'h04, 16'h0011, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h04, 8'h04, 16'h00AA, 1'b0, 1'b0, 1'b0);
`ifdef REG_BANK_BYPASS_EN
    chk("same reg bypass", 32'(dataOut), 32'h00AA);
`else
    chk("same reg stored", 32'(dataOut), 32'h0011);
`endif
    tick();
    readReg("r2 after write", 2, 16'h00AA); tick();

    // Reset overrides loads, pcInc and clears everything.
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, 8'(1 << i), 16'(16'h1111 * (i + 1)), 1'b0, 1'b0, 1'b0); tick();
    end
    drive(8'h00, 8'h30, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("err before rst", 32'(errFlag), 32'h1);
    readReg("r5 before rst", 5, 16'h6666);
    drive(8'h00, 8'h01, 16'h5555, 1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 8; i++) begin
      readReg($sformatf("r%0d after rst", i), i, 16'h0000);
    end
    chk("err after rst", 32'(errFlag), 32'h0);
    tick();

    // Idle bus leaves the flag alone.
    drive(8'h81, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    chk("idle dataOut", 32'(dataOut), 32'h0);
    chk("idle busDriven", 32'(busDriven), 32'h0);
    chk("idle errFlag", 32'(errFlag), 32'h1);

    // Randomized traffic checked by the model process.
    for (int n = 0; n < 3000; n++) begin
      drive(randStrobe(), randStrobe(), 16'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 59) == 0));
      tick();
    end

    drive(8'h00, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
